// File: rtl/fft4_frame_sequencer.sv
// Frame sequencer that runs an external combinational 4-point butterfly stage
// twice per frame to form a 4-point DFT, then streams the bins out in order.
module fft4_frame_sequencer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_re,
  input  logic [W-1:0] in_im,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_re,
  output logic [W-1:0] out_im,
  output logic [1:0]   out_idx,
  output logic         out_last,
  output logic [W-1:0] st_ar,
  output logic [W-1:0] st_ai,
  output logic [W-1:0] st_br,
  output logic [W-1:0] st_bi,
  output logic [W-1:0] st_cr,
  output logic [W-1:0] st_ci,
  output logic [W-1:0] st_dr,
  output logic [W-1:0] st_di,
  input  logic [W-1:0] st_xr0,
  input  logic [W-1:0] st_xi0,
  input  logic [W-1:0] st_xr1,
  input  logic [W-1:0] st_xi1,
  input  logic [W-1:0] st_xr2,
  input  logic [W-1:0] st_xi2,
  input  logic [W-1:0] st_xr3,
  input  logic [W-1:0] st_xi3
);

  typedef enum logic [1:0] {LOAD, PASS1, PASS2, OUT} state_t;

  state_t       state_reg, state_next;
  logic [1:0]   load_cnt_reg;
  logic [1:0]   out_idx_reg;
  logic [W-1:0] smp_re_reg [4];
  logic [W-1:0] smp_im_reg [4];
  // Holds the pass-1 intermediates, then is overwritten with the final bins.
  logic [W-1:0] mid_re_reg [4];
  logic [W-1:0] mid_im_reg [4];
  logic [W-1:0] x_re [4];
  logic [W-1:0] x_im [4];

  assign x_re[0] = st_xr0;
  assign x_im[0] = st_xi0;
  assign x_re[1] = st_xr1;
  assign x_im[1] = st_xi1;
  assign x_re[2] = st_xr2;
  assign x_im[2] = st_xi2;
  assign x_re[3] = st_xr3;
  assign x_im[3] = st_xi3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= LOAD;
      load_cnt_reg <= 2'd0;
      out_idx_reg  <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        smp_re_reg[i] <= '0;
        smp_im_reg[i] <= '0;
        mid_re_reg[i] <= '0;
        mid_im_reg[i] <= '0;
      end
    end else begin
      state_reg <= state_next;
      case (state_reg)
        LOAD: begin
          if (in_valid) begin
            smp_re_reg[load_cnt_reg] <= in_re;
            smp_im_reg[load_cnt_reg] <= in_im;
            load_cnt_reg             <= load_cnt_reg + 2'd1;
          end
        end
        PASS1, PASS2: begin
          for (int i = 0; i < 4; i++) begin
            mid_re_reg[i] <= x_re[i];
            mid_im_reg[i] <= x_im[i];
          end
        end
        OUT: begin
          if (out_ready) out_idx_reg <= out_idx_reg + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_re     = '0;
    out_im     = '0;
    out_idx    = out_idx_reg;
    out_last   = 1'b0;
    st_ar      = '0;
    st_ai      = '0;
    st_br      = '0;
    st_bi      = '0;
    st_cr      = '0;
    st_ci      = '0;
    st_dr      = '0;
    st_di      = '0;
    case (state_reg)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && load_cnt_reg == 2'd3) state_next = PASS1;
      end
      PASS1: begin
        st_ar      = smp_re_reg[0];
        st_ai      = smp_im_reg[0];
        st_br      = smp_re_reg[1];
        st_bi      = smp_im_reg[1];
        st_cr      = smp_re_reg[2];
        st_ci      = smp_im_reg[2];
        st_dr      = smp_re_reg[3];
        st_di      = smp_im_reg[3];
        state_next = PASS2;
      end
      PASS2: begin
        // Operands B and C swap; D is rotated by -j: (r, i) -> (i, -r).
        st_ar      = mid_re_reg[0];
        st_ai      = mid_im_reg[0];
        st_br      = mid_re_reg[2];
        st_bi      = mid_im_reg[2];
        st_cr      = mid_re_reg[1];
        st_ci      = mid_im_reg[1];
        st_dr      = mid_im_reg[3];
        st_di      = '0 - mid_re_reg[3];
        state_next = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        out_re    = mid_re_reg[out_idx_reg];
        out_im    = mid_im_reg[out_idx_reg];
        out_last  = (out_idx_reg == 2'd3);
        if (out_ready && out_idx_reg == 2'd3) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

endmodule

// File: tb/tb_fft4_frame_sequencer.sv
// Randomised and directed bench: a direct-DFT model predicts every bin and the
// per-cycle handshake/stage behaviour, checked at each falling edge.
module tb_fft4_frame_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_re = '0;
  logic [W-1:0] in_im = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_re, out_im;
  logic [1:0]   out_idx;
  logic         out_last;
  logic [W-1:0] st_ar, st_ai, st_br, st_bi, st_cr, st_ci, st_dr, st_di;
  logic [W-1:0] st_xr0, st_xi0, st_xr1, st_xi1, st_xr2, st_xi2, st_xr3, st_xi3;

  always #5 clk = ~clk;

  fft4_frame_sequencer #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_idx(out_idx), .out_last(out_last),
    .st_ar(st_ar), .st_ai(st_ai), .st_br(st_br), .st_bi(st_bi),
    .st_cr(st_cr), .st_ci(st_ci), .st_dr(st_dr), .st_di(st_di),
    .st_xr0(st_xr0), .st_xi0(st_xi0), .st_xr1(st_xr1), .st_xi1(st_xi1),
    .st_xr2(st_xr2), .st_xi2(st_xi2), .st_xr3(st_xr3), .st_xi3(st_xi3)
  );

  // External butterfly stage
  assign st_xr0 = st_ar + st_cr;
  assign st_xi0 = st_ai + st_ci;
  assign st_xr1 = st_br + st_dr;
  assign st_xi1 = st_bi + st_di;
  assign st_xr2 = st_ar - st_cr;
  assign st_xi2 = st_ai - st_ci;
  assign st_xr3 = st_br - st_dr;
  assign st_xi3 = st_bi - st_di;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout got=expired exp=event", name);
  endtask

  typedef struct packed {
    logic [31:0] re;
    logic [31:0] im;
    logic [1:0]  idx;
  } bin_t;

  bin_t        exp_q[$];
  logic [31:0] m_re [4];
  logic [31:0] m_im [4];
  logic [31:0] p2_dr, p2_di;
  int          m_cnt = 0;
  int          pend = 0;
  logic [31:0] cap_re [4];
  logic [31:0] cap_im [4];
  bit          rand_ready_en = 0;

  // Direct 4-point DFT: X[k] = sum x[n] * (-j)^(n*k), modulo 2^32.
  function automatic void push_frame();
    logic [31:0] ar, ai, br, bi, cr, ci, dr, di;
    bin_t b;
    ar = m_re[0]; ai = m_im[0]; br = m_re[1]; bi = m_im[1];
    cr = m_re[2]; ci = m_im[2]; dr = m_re[3]; di = m_im[3];
    b.idx = 2'd0; b.re = ar + br + cr + dr; b.im = ai + bi + ci + di; exp_q.push_back(b);
    b.idx = 2'd1; b.re = ar + bi - cr - di; b.im = ai - br - ci + dr; exp_q.push_back(b);
    b.idx = 2'd2; b.re = ar - br + cr - dr; b.im = ai - bi + ci - di; exp_q.push_back(b);
    b.idx = 2'd3; b.re = ar - bi - cr + di; b.im = ai + br - ci - dr; exp_q.push_back(b);
    p2_dr = bi - di;
    p2_di = dr - br;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_cnt = 0;
      pend  = 0;
      check("rst_out", 256'({in_ready, out_valid, out_re, out_im, out_idx, out_last}),
            256'({1'b1, 1'b0, 64'd0, 2'd0, 1'b0}));
      check("rst_st", {st_ar, st_ai, st_br, st_bi, st_cr, st_ci, st_dr, st_di}, 256'd0);
    end else begin
      if (pend > 0) pend--;
      check("in_ready", 256'(in_ready), 256'(exp_q.size() == 0));
      check("out_valid", 256'(out_valid), 256'(exp_q.size() > 0 && pend == 0));
      if (pend == 2)
        check("st_pass1", {st_ar, st_ai, st_br, st_bi, st_cr, st_ci, st_dr, st_di},
              {m_re[0], m_im[0], m_re[1], m_im[1], m_re[2], m_im[2], m_re[3], m_im[3]});
      else if (pend == 1)
        check("st_pass2_d", 256'({st_dr, st_di}), 256'({p2_dr, p2_di}));
      else
        check("st_idle", {st_ar, st_ai, st_br, st_bi, st_cr, st_ci, st_dr, st_di}, 256'd0);
      if (exp_q.size() > 0 && pend == 0) begin
        check("bin", 256'({out_re, out_im, out_idx, out_last}),
              256'({exp_q[0].re, exp_q[0].im, exp_q[0].idx, exp_q[0].idx == 2'd3}));
        if (out_ready) begin
          cap_re[exp_q[0].idx] = out_re;
          cap_im[exp_q[0].idx] = out_im;
          void'(exp_q.pop_front());
        end
      end else if (in_valid && exp_q.size() == 0) begin
        m_re[m_cnt] = in_re;
        m_im[m_cnt] = in_im;
        m_cnt++;
        if (m_cnt == 4) begin
          push_frame();
          m_cnt = 0;
          pend  = 3;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready_en) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [31:0] re, input logic [31:0] im, input int gap);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_re    = re;
    in_im    = im;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    timeout_fail("send");
  endtask

  task automatic send4(input logic [255:0] s);
    for (int i = 0; i < 4; i++)
      send(s[255-64*i -: 32], s[223-64*i -: 32], 0);
  endtask

  task automatic wait_done();
    for (int t = 0; t < 300; t++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) return;
    end
    timeout_fail("wait_done");
  endtask

  task automatic wait_valid();
    for (int t = 0; t < 50; t++) begin
      @(posedge clk);
      #1;
      if (out_valid) return;
    end
    timeout_fail("wait_valid");
  endtask

  task automatic clear_cap();
    for (int i = 0; i < 4; i++) begin
      cap_re[i] = 32'hDEAD_BEEF;
      cap_im[i] = 32'hDEAD_BEEF;
    end
  endtask

  task automatic check_bins(input string name, input logic [255:0] e);
    check(name, {cap_re[0], cap_im[0], cap_re[1], cap_im[1], cap_re[2], cap_im[2], cap_re[3], cap_im[3]}, e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_immediate", 256'({in_ready, out_valid, out_re, out_im, out_idx, out_last}),
          256'({1'b1, 1'b0, 64'd0, 2'd0, 1'b0}));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  localparam logic [255:0] IMPULSE     = {32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
  localparam logic [255:0] IMPULSE_OUT = {32'd1, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0};

  initial begin
    #1;
    check("rst_initial", 256'({in_ready, out_valid, out_idx, out_last}), 256'({1'b1, 1'b0, 2'd0, 1'b0}));
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    clear_cap();
    send4(IMPULSE);
    wait_done();
    check_bins("impulse", IMPULSE_OUT);

    clear_cap();
    send4({32'd0, 32'd0, 32'd1, 32'd0, 32'd2, 32'd0, 32'd3, 32'd0});
    wait_done();
    check_bins("ramp", {32'd6, 32'd0, -32'sd2, 32'd2, -32'sd2, 32'd0, -32'sd2, -32'sd2});

    clear_cap();
    send4({32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1});
    wait_done();
    check_bins("constant", {32'd4, 32'd4, 192'd0});

    // Backpressure with an ignored input offered during the hold
    clear_cap();
    out_ready = 1'b0;
    send4({32'd1, 32'd0, 32'd2, 32'd0, 32'd3, 32'd0, 32'd4, 32'd0});
    wait_valid();
    in_valid = 1'b1;
    in_re    = 32'h1234_5678;
    in_im    = 32'h9ABC_DEF0;
    repeat (5) begin
      @(negedge clk);
      check("bp_hold", 256'({out_idx, in_ready, out_valid, out_re, out_im}),
            256'({2'd0, 1'b0, 1'b1, 32'd10, 32'd0}));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_done();
    check_bins("backpressure", {32'd10, 32'd0, -32'sd2, 32'd2, -32'sd2, 32'd0, -32'sd2, -32'sd2});

    clear_cap();
    send4({32'h7FFF_FFFF, 32'd0, 32'h7FFF_FFFF, 32'd0, 32'h7FFF_FFFF, 32'd0, 32'h7FFF_FFFF, 32'd0});
    wait_done();
    check_bins("wrap", {32'hFFFF_FFFC, 32'd0, 192'd0});

    // Reset with a partial frame loaded
    send(32'd5, 32'd6, 0);
    send(32'd7, 32'd8, 0);
    do_reset();
    clear_cap();
    send4(IMPULSE);
    wait_done();
    check_bins("impulse_after_load_rst", IMPULSE_OUT);

    // Reset with two bins already delivered
    out_ready = 1'b0;
    send4({32'd9, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7});
    wait_valid();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_idx_before_rst", 256'(out_idx), 256'(2'd2));
    do_reset();
    out_ready = 1'b1;
    clear_cap();
    send4(IMPULSE);
    wait_done();
    check_bins("impulse_after_out_rst", IMPULSE_OUT);

    rand_ready_en = 1;
    for (int f = 0; f < 20; f++)
      for (int s = 0; s < 4; s++)
        send($urandom, $urandom, $urandom_range(0, 2));
    wait_done();
    rand_ready_en = 0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
